// File: rtl/multikey_debounce_if.sv
// Key front-end bundle: raw keys in, debounced level and event pulses out.
interface multikey_debounce_if #(
  parameter int NKEYS = 3
);
  logic [NKEYS-1:0] key_raw;
  logic [NKEYS-1:0] key_state;
  logic [NKEYS-1:0] key_press;
  logic [NKEYS-1:0] key_release;
  logic [NKEYS-1:0] key_repeat;
  logic             tick;

  modport master (output key_raw, input key_state, key_press, key_release, key_repeat, tick);
  modport slave  (input key_raw, output key_state, key_press, key_release, key_repeat, tick);
endinterface

// File: rtl/multikey_debounce.sv
// N-key debouncer: heartbeat-sampled shift registers with hysteresis, optional
// exclusive (no-chord) qualification and per-key auto-repeat.
module multikey_debounce #(
  parameter int NKEYS        = 3,
  parameter int HB_BITS      = 21,
  parameter int DEPTH        = 3,
  parameter int EXCLUSIVE    = 1,
  parameter int REPEAT_DELAY = 32,
  parameter int REPEAT_RATE  = 8
) (
  input  logic               sysclk,
  input  logic               reset,
  multikey_debounce_if.slave kif
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  // A rate longer than the delay cannot be expressed as a reload; fall back to 0.
  localparam int RELOAD = (REPEAT_RATE >= REPEAT_DELAY) ? 0 : REPEAT_DELAY - REPEAT_RATE;
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RLOAD = RW'(RELOAD);

  logic [HB_BITS-1:0]            hb_q, hb_d;
  logic                          tick;
  logic                          solo;
  logic [NKEYS-1:0]              samp;
  logic [NKEYS-1:0][DEPTH-1:0]   sr_q, sr_d;
  logic [NKEYS-1:0]              state_q, state_d;
  logic [NKEYS-1:0][RW-1:0]      rcnt_q, rcnt_d;
  logic [NKEYS-1:0]              press_q, press_d;
  logic [NKEYS-1:0]              rel_q, rel_d;
  logic [NKEYS-1:0]              rep_q, rep_d;

  assign hb_d = hb_q + 1'b1;
  assign tick = &hb_q;

  // At most one raw bit set; a lone high key is then by definition the sole one.
  assign solo = (kif.key_raw & (kif.key_raw - 1'b1)) == '0;
  assign samp = ((EXCLUSIVE == 0) || solo) ? kif.key_raw : '0;

  always_comb begin
    sr_d    = sr_q;
    state_d = state_q;
    rcnt_d  = rcnt_q;
    press_d = '0;
    rel_d   = '0;
    rep_d   = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (tick) sr_d[i] = {sr_q[i][DEPTH-2:0], samp[i]};
      if (!state_q[i] && (&sr_q[i]))      state_d[i] = 1'b1;
      else if (state_q[i] && !(|sr_q[i])) state_d[i] = 1'b0;
      press_d[i] = state_d[i] & ~state_q[i];
      rel_d[i]   = state_q[i] & ~state_d[i];
      // Edges take priority so a repeat can never share a cycle with press/release.
      if (REPEAT_RATE == 0 || press_d[i] || rel_d[i]) begin
        rcnt_d[i] = '0;
      end else if (tick && state_q[i]) begin
        if (rcnt_q[i] == RLAST) begin
          rcnt_d[i] = RLOAD;
          rep_d[i]  = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      hb_q    <= '0;
      sr_q    <= '0;
      state_q <= '0;
      rcnt_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      rep_q   <= '0;
    end else begin
      hb_q    <= hb_d;
      sr_q    <= sr_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
    end
  end

  assign kif.key_state   = state_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = rel_q;
  assign kif.key_repeat  = rep_q;
  assign kif.tick        = tick;
endmodule

// File: tb/tb_multikey_debounce.sv
// Directed bench: HB_BITS=2 so ticks land on cycles 3,7,11,...; cycle numbers
// count from the first cycle with reset low.
module tb_multikey_debounce;
  localparam int NK = 3;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always #5 sysclk = ~sysclk;

  multikey_debounce_if #(.NKEYS(NK)) kif ();

  multikey_debounce #(
    .NKEYS(NK), .HB_BITS(2), .DEPTH(3), .EXCLUSIVE(1),
    .REPEAT_DELAY(4), .REPEAT_RATE(2)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .kif   (kif.slave)
  );

  task automatic step();
    @(posedge sysclk);
    #1;
    cyc++;
  endtask

  // One-cycle reset pulse; returns positioned in cycle 0.
  task automatic restart(input logic [NK-1:0] raw);
    reset       = 1'b1;
    kif.key_raw = raw;
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    kif.key_raw = 3'b111;
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if ({kif.key_state, kif.key_press, kif.key_release, kif.key_repeat, kif.tick} !== 13'b0) begin
        errors++;
        $display("FAIL reset_outputs n=%0d got st=%b pr=%b rl=%b rp=%b tk=%b want all 0",
                 n, kif.key_state, kif.key_press, kif.key_release, kif.key_repeat, kif.tick);
      end
    end
  endtask

  task automatic test_press();
    logic [NK-1:0] e_st, e_pr;
    restart(3'b001);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) step();
      e_st = (cyc >= 13) ? 3'b001 : 3'b000;
      e_pr = (cyc == 13) ? 3'b001 : 3'b000;
      checks++;
      if (kif.tick !== (cyc % 4 == 3)) begin
        errors++;
        $display("FAIL tick cyc=%0d got=%b want=%b", cyc, kif.tick, (cyc % 4 == 3));
      end
      checks++;
      if (kif.key_state !== e_st || kif.key_press !== e_pr) begin
        errors++;
        $display("FAIL press cyc=%0d got st=%b pr=%b want st=%b pr=%b",
                 cyc, kif.key_state, kif.key_press, e_st, e_pr);
      end
    end
  endtask

  task automatic test_repeat();
    logic [NK-1:0] e_rp;
    for (int c = 15; c <= 40; c++) begin
      step();
      e_rp = (cyc == 28 || cyc == 36) ? 3'b001 : 3'b000;
      checks++;
      if (kif.key_repeat !== e_rp || kif.key_press !== 3'b000 || kif.key_state !== 3'b001) begin
        errors++;
        $display("FAIL repeat cyc=%0d got rp=%b pr=%b st=%b want rp=%b pr=000 st=001",
                 cyc, kif.key_repeat, kif.key_press, kif.key_state, e_rp);
      end
    end
    kif.key_raw = 3'b000;
  endtask

  task automatic test_release();
    logic [NK-1:0] e_st, e_rl, e_rp;
    for (int c = 41; c <= 60; c++) begin
      step();
      e_st = (cyc <= 52) ? 3'b001 : 3'b000;
      e_rl = (cyc == 53) ? 3'b001 : 3'b000;
      e_rp = (cyc == 44 || cyc == 52) ? 3'b001 : 3'b000;
      checks++;
      if (kif.key_state !== e_st || kif.key_release !== e_rl || kif.key_repeat !== e_rp) begin
        errors++;
        $display("FAIL release cyc=%0d got st=%b rl=%b rp=%b want st=%b rl=%b rp=%b",
                 cyc, kif.key_state, kif.key_release, kif.key_repeat, e_st, e_rl, e_rp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [NK-1:0] e_st, e_pr;
    for (int k = 0; k < 10; k++) begin
      kif.key_raw = (k % 2 == 0) ? 3'b001 : 3'b000;
      for (int n = 0; n < 4; n++) begin
        step();
        checks++;
        if (kif.key_state !== 3'b000 || kif.key_press !== 3'b000 || kif.key_release !== 3'b000) begin
          errors++;
          $display("FAIL bounce cyc=%0d got st=%b pr=%b rl=%b want all 000",
                   cyc, kif.key_state, kif.key_press, kif.key_release);
        end
      end
    end
    kif.key_raw = 3'b001;
    for (int n = 0; n < 16; n++) begin
      step();
      e_st = (cyc >= 113) ? 3'b001 : 3'b000;
      e_pr = (cyc == 113) ? 3'b001 : 3'b000;
      checks++;
      if (kif.key_state !== e_st || kif.key_press !== e_pr) begin
        errors++;
        $display("FAIL bounce_hold cyc=%0d got st=%b pr=%b want st=%b pr=%b",
                 cyc, kif.key_state, kif.key_press, e_st, e_pr);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [NK-1:0] e_st, e_pr;
    checks++;
    if (kif.key_state !== 3'b001) begin
      errors++;
      $display("FAIL midop_pre cyc=%0d got st=%b want 001", cyc, kif.key_state);
    end
    restart(3'b001);
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) step();
      e_st = (cyc >= 13) ? 3'b001 : 3'b000;
      e_pr = (cyc == 13) ? 3'b001 : 3'b000;
      checks++;
      if (kif.key_state !== e_st || kif.key_press !== e_pr ||
          kif.key_release !== 3'b000 || kif.key_repeat !== 3'b000) begin
        errors++;
        $display("FAIL midop_reset cyc=%0d got st=%b pr=%b rl=%b rp=%b want st=%b pr=%b rl=000 rp=000",
                 cyc, kif.key_state, kif.key_press, kif.key_release, kif.key_repeat, e_st, e_pr);
      end
    end
  endtask

  task automatic test_exclusive();
    logic [NK-1:0] e_st, e_pr, e_rl, e_rp;
    restart(3'b010);
    for (int c = 0; c <= 56; c++) begin
      if (c > 0) step();
      e_st = (cyc >= 13 && cyc <= 28) ? 3'b010 : (cyc >= 53) ? 3'b001 : 3'b000;
      e_pr = (cyc == 13) ? 3'b010 : (cyc == 53) ? 3'b001 : 3'b000;
      e_rl = (cyc == 29) ? 3'b010 : 3'b000;
      e_rp = (cyc == 28) ? 3'b010 : 3'b000;
      checks++;
      if (kif.key_state !== e_st || kif.key_press !== e_pr ||
          kif.key_release !== e_rl || kif.key_repeat !== e_rp) begin
        errors++;
        $display("FAIL exclusive cyc=%0d got st=%b pr=%b rl=%b rp=%b want st=%b pr=%b rl=%b rp=%b",
                 cyc, kif.key_state, kif.key_press, kif.key_release, kif.key_repeat,
                 e_st, e_pr, e_rl, e_rp);
      end
      if (cyc == 16) kif.key_raw = 3'b011;
      if (cyc == 40) kif.key_raw = 3'b001;
    end
  endtask

  initial begin
    kif.key_raw = '0;
    test_reset();
    test_press();
    test_repeat();
    test_release();
    test_bounce();
    test_reset_midop();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
